// File: rtl/fft_pkg.sv
// Shared widths, pipeline types and helper functions for the FFT spectral-peak detector.
package fft_pkg;

  localparam int DEF_BIT_WIDTH = 16;
  localparam int DEF_N         = 9;
  localparam int DEF_FS        = 48000;
  localparam int DEF_KMIN      = 1;
  localparam int DEF_KMAX      = 255;
  localparam int DEF_FREQ_W    = DEF_BIT_WIDTH + 1;

  localparam int FFT_SIZE = 2 ** DEF_N;
  localparam int MAG_W    = 2 * DEF_BIT_WIDTH;

  typedef logic [DEF_N-1:0] bin_idx_t;
  typedef logic [MAG_W-1:0] mag_t;

  // Running maximum; 'any' marks that at least one in-window bin has been seen.
  typedef struct packed {
    mag_t     mag;
    bin_idx_t bin;
    logic     any;
  } peak_t;

  // Travels alongside each bin through the magnitude stage.
  typedef struct packed {
    bin_idx_t idx;
    logic     last;
  } tag_t;

  // Bin index to Hz: bin * fs / FFT_SIZE, truncated (constant multiply + shift).
  function automatic logic [DEF_FREQ_W-1:0] bin_to_hz(input bin_idx_t bin, input int unsigned fs);
    logic [DEF_N+31:0] prod;
    prod = {32'b0, bin} * {{DEF_N{1'b0}}, fs};
    return DEF_FREQ_W'(prod >> DEF_N);
  endfunction

  function automatic logic in_window(input bin_idx_t idx, input int unsigned kmin,
                                     input int unsigned kmax);
    return (32'(idx) >= kmin) && (32'(idx) <= kmax);
  endfunction

endpackage

// File: rtl/fft_peak_detect_if.sv
// Bin stream in, per-frame peak report out, between the FFT core and the note decoder.
interface fft_peak_detect_if import fft_pkg::*; #(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int N         = DEF_N,
  parameter int FREQ_W    = DEF_FREQ_W
);

  // Handshake: bin_valid qualifies bin_data/frame_start with no ready (every valid bin is
  // accepted); peak_valid is a one-cycle pulse and the peak_* / frequency values hold after it.
  logic                   bin_valid;
  logic [2*BIT_WIDTH-1:0] bin_data;
  logic                   frame_start;
  logic [2*BIT_WIDTH-1:0] mag_thresh;

  logic                   peak_valid;
  logic                   peak_found;
  logic [N-1:0]           peak_bin;
  logic [2*BIT_WIDTH-1:0] peak_mag;
  logic [FREQ_W-1:0]      frequency;

  modport master (
    output bin_valid, bin_data, frame_start, mag_thresh,
    input  peak_valid, peak_found, peak_bin, peak_mag, frequency
  );

  modport slave (
    input  bin_valid, bin_data, frame_start, mag_thresh,
    output peak_valid, peak_found, peak_bin, peak_mag, frequency
  );

endinterface

// File: rtl/mag_sq.sv
// One-cycle registered full-precision squared magnitude re^2 + im^2 with tag passthrough.
module mag_sq import fft_pkg::*; #(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic signed [BIT_WIDTH-1:0]   re,
  input  logic signed [BIT_WIDTH-1:0]   im,
  input  tag_t                          in_tag,
  output logic                          out_valid,
  output logic        [2*BIT_WIDTH-1:0] out_mag,
  output tag_t                          out_tag
);

  logic signed [2*BIT_WIDTH-1:0] re_ext;
  logic signed [2*BIT_WIDTH-1:0] im_ext;
  logic signed [2*BIT_WIDTH-1:0] re_sq;
  logic signed [2*BIT_WIDTH-1:0] im_sq;

  // Each square is at most 2^(2BW-2), so the unsigned sum cannot overflow 2*BW bits.
  assign re_ext = {{BIT_WIDTH{re[BIT_WIDTH-1]}}, re};
  assign im_ext = {{BIT_WIDTH{im[BIT_WIDTH-1]}}, im};
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_mag   <= '0;
      out_tag   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_mag <= $unsigned(re_sq) + $unsigned(im_sq);
        out_tag <= in_tag;
      end
    end
  end

endmodule

// File: rtl/fft_peak_detect.sv
// Streaming spectral-peak detector: input register, squared magnitude, windowed max tracker
// and per-frame thresholded report. Widths follow fft_pkg; parameters must match its defaults.
module fft_peak_detect import fft_pkg::*; #(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int N         = DEF_N,
  parameter int FS        = DEF_FS,
  parameter int KMIN      = DEF_KMIN,
  parameter int KMAX      = DEF_KMAX,
  parameter int FREQ_W    = DEF_FREQ_W
) (
  input  logic                clk,
  input  logic                reset,
  fft_peak_detect_if.slave    bus
);

  // ---------------- stage 0: index counter and input register ----------------
  logic [N-1:0]                k;
  bin_idx_t                    cur_idx;
  logic                        s0_valid;
  logic signed [BIT_WIDTH-1:0] s0_re;
  logic signed [BIT_WIDTH-1:0] s0_im;
  tag_t                        s0_tag;

  assign cur_idx = bus.frame_start ? '0 : k;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k        <= '0;
      s0_valid <= 1'b0;
      s0_re    <= '0;
      s0_im    <= '0;
      s0_tag   <= '0;
    end else begin
      s0_valid <= bus.bin_valid;
      if (bus.bin_valid) begin
        k        <= cur_idx + 1'b1;
        s0_re    <= bus.bin_data[2*BIT_WIDTH-1:BIT_WIDTH];
        s0_im    <= bus.bin_data[BIT_WIDTH-1:0];
        s0_tag   <= '{idx: cur_idx, last: (cur_idx == bin_idx_t'(FFT_SIZE - 1))};
      end
    end
  end

  // ---------------- stage 1: squared magnitude ----------------
  logic                   s1_valid;
  logic [2*BIT_WIDTH-1:0] s1_mag;
  tag_t                   s1_tag;

  mag_sq #(.BIT_WIDTH(BIT_WIDTH)) u_mag_sq (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s0_valid),
    .re        (s0_re),
    .im        (s0_im),
    .in_tag    (s0_tag),
    .out_valid (s1_valid),
    .out_mag   (s1_mag),
    .out_tag   (s1_tag)
  );

  // ---------------- stage 2: tracker and frame-end report ----------------
  peak_t                  run_max;
  peak_t                  cand;
  logic                   found_d;
  logic [DEF_FREQ_W-1:0]  freq_d;

  // Bin 0 starts from an empty max, so the last bin of one frame and bin 0 of the next
  // can sit in consecutive cycles without sharing state.
  always_comb begin
    cand = (s1_tag.idx == '0) ? '0 : run_max;
    if (in_window(s1_tag.idx, KMIN, KMAX) && (!cand.any || (s1_mag > cand.mag))) begin
      cand = '{mag: s1_mag, bin: s1_tag.idx, any: 1'b1};
    end
    found_d = (cand.mag >= bus.mag_thresh);
  end

  assign freq_d = bin_to_hz(cand.bin, FS);

  logic                   peak_valid_r;
  logic                   peak_found_r;
  logic [N-1:0]           peak_bin_r;
  logic [2*BIT_WIDTH-1:0] peak_mag_r;
  logic [FREQ_W-1:0]      freq_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_max      <= '0;
      peak_valid_r <= 1'b0;
      peak_found_r <= 1'b0;
      peak_bin_r   <= '0;
      peak_mag_r   <= '0;
      freq_r       <= '0;
    end else begin
      peak_valid_r <= 1'b0;
      if (s1_valid) begin
        run_max <= cand;
        if (s1_tag.last) begin
          peak_valid_r <= 1'b1;
          peak_found_r <= found_d;
          peak_bin_r   <= found_d ? cand.bin : '0;
          peak_mag_r   <= found_d ? cand.mag : '0;
          freq_r       <= found_d ? freq_d   : '0;
        end
      end
    end
  end

  assign bus.peak_valid = peak_valid_r;
  assign bus.peak_found = peak_found_r;
  assign bus.peak_bin   = peak_bin_r;
  assign bus.peak_mag   = peak_mag_r;
  assign bus.frequency  = freq_r;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect: directed spectra plus randomized frames against a
// whole-frame reference model.
module tb_fft_peak_detect;
  import fft_pkg::*;

  localparam int FSZ   = 512;
  localparam int FS_HZ = 48000;
  localparam int K_LO  = 1;
  localparam int K_HI  = 255;

  typedef struct packed {
    logic        found;
    logic [8:0]  bin;
    logic [31:0] mag;
    logic [16:0] freq;
  } res_t;
  localparam int RES_W = $bits(res_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fft_peak_detect_if bus ();

  fft_peak_detect dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- monitor / scoreboard queues ----------------
  res_t             got_q[$];
  int unsigned      got_cyc_q[$];
  logic [RES_W-1:0] exp_q[$];
  int unsigned      exp_cyc_q[$];

  always @(negedge clk) begin
    if (bus.peak_valid === 1'b1) begin
      got_q.push_back('{found: bus.peak_found, bin: bus.peak_bin, mag: bus.peak_mag,
                        freq: bus.frequency});
      got_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [31:0] frame[FSZ];

  function automatic res_t model_frame(input logic [31:0] thr);
    longint best;
    int best_k;
    longint m;
    logic signed [15:0] re;
    logic signed [15:0] im;
    res_t r;
    best = -1;
    best_k = 0;
    for (int i = K_LO; i <= K_HI; i++) begin
      re = frame[i][31:16];
      im = frame[i][15:0];
      m = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      if (m > best) begin
        best = m;
        best_k = i;
      end
    end
    r = '0;
    if (best >= longint'(thr)) begin
      r.found = 1'b1;
      r.bin   = best_k[8:0];
      r.mag   = best[31:0];
      r.freq  = 17'((best_k * FS_HZ) / FSZ);
    end
    return r;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("found=%0b bin=%0d mag=%h freq=%0d", r.found, r.bin, r.mag, r.freq);
  endfunction

  function automatic void clear_frame();
    for (int i = 0; i < FSZ; i++) frame[i] = '0;
  endfunction

  function automatic void clear_got();
    got_q.delete();
    got_cyc_q.delete();
    exp_q.delete();
    exp_cyc_q.delete();
  endfunction

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    bus.bin_valid   = 1'b0;
    bus.frame_start = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bin(input logic [31:0] d, input logic fs);
    bus.bin_valid   = 1'b1;
    bus.bin_data    = d;
    bus.frame_start = fs;
    @(posedge clk);
    #1;
  endtask

  // Drives the whole frame; e0 is the cycle stamp of the edge that sampled the last bin.
  task automatic drive_frame(input int gap_pct, output int unsigned e0);
    int gaps;
    for (int i = 0; i < FSZ; i++) begin
      gaps = 0;
      while (gap_pct > 0 && gaps < 3 && $urandom_range(0, 99) < gap_pct) begin
        bus.bin_valid   = 1'b0;
        bus.frame_start = 1'($urandom_range(0, 1));
        bus.bin_data    = $urandom;
        @(posedge clk);
        #1;
        gaps++;
      end
      drive_bin(frame[i], i == 0);
    end
    e0 = cyc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    res_t now;
    reset = 1'b1;
    idle(3);
    now = '{found: bus.peak_found, bin: bus.peak_bin, mag: bus.peak_mag, freq: bus.frequency};
    tests_run++;
    if (bus.peak_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_peak_valid: got %b expected 0", bus.peak_valid);
    end
    tests_run++;
    if (now !== res_t'(0)) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %s expected all zero", fmt(now));
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_single_tone();
    res_t exp_r;
    int unsigned e0;
    clear_frame();
    clear_got();
    frame[10] = 32'h4000_0000;
    bus.mag_thresh = 32'd1;
    drive_frame(0, e0);
    idle(5);
    exp_r = '{found: 1'b1, bin: 9'd10, mag: 32'h1000_0000, freq: 17'd937};
    tests_run++;
    if (got_q.size() !== 1) begin
      tests_failed++;
      $display("FAIL single_tone_count: got %0d pulses expected 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      tests_run++;
      if (got_cyc_q[0] !== e0 + 2) begin
        tests_failed++;
        $display("FAIL single_tone_latency: got cycle %0d expected %0d", got_cyc_q[0], e0 + 2);
      end
      tests_run++;
      if (got_q[0] !== exp_r) begin
        tests_failed++;
        $display("FAIL single_tone_result: got %s expected %s", fmt(got_q[0]), fmt(exp_r));
      end
    end
    tests_run++;
    if (bus.peak_bin !== 9'd10 || bus.peak_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_tone_hold: got bin=%0d valid=%b expected bin=10 valid=0",
               bus.peak_bin, bus.peak_valid);
    end
  endtask

  task automatic test_tie_window();
    res_t exp_r;
    int unsigned e0;
    clear_frame();
    clear_got();
    frame[0]   = 32'h7fff_7fff;
    frame[300] = 32'h7fff_7fff;
    frame[20]  = 32'h1000_1000;
    frame[40]  = 32'h1000_1000;
    bus.mag_thresh = 32'd1;
    drive_frame(0, e0);
    idle(5);
    exp_r = '{found: 1'b1, bin: 9'd20, mag: 32'h0200_0000, freq: 17'd1875};
    tests_run++;
    if (got_q.size() !== 1) begin
      tests_failed++;
      $display("FAIL tie_window_count: got %0d pulses expected 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      tests_run++;
      if (got_q[0] !== exp_r) begin
        tests_failed++;
        $display("FAIL tie_window_result: got %s expected %s", fmt(got_q[0]), fmt(exp_r));
      end
    end
  endtask

  task automatic test_threshold();
    res_t exp_r;
    int unsigned e0;
    // One above the peak: reported as not found, but the frame still pulses.
    clear_frame();
    clear_got();
    frame[10] = 32'h4000_0000;
    bus.mag_thresh = 32'h1000_0001;
    drive_frame(0, e0);
    idle(5);
    tests_run++;
    if (got_q.size() !== 1) begin
      tests_failed++;
      $display("FAIL threshold_above_count: got %0d pulses expected 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      tests_run++;
      if (got_q[0] !== res_t'(0)) begin
        tests_failed++;
        $display("FAIL threshold_above_result: got %s expected all zero", fmt(got_q[0]));
      end
    end
    // Exactly equal to the peak counts as found.
    clear_got();
    bus.mag_thresh = 32'h1000_0000;
    drive_frame(0, e0);
    idle(5);
    exp_r = '{found: 1'b1, bin: 9'd10, mag: 32'h1000_0000, freq: 17'd937};
    tests_run++;
    if (got_q.size() !== 1 || got_q[0] !== exp_r) begin
      tests_failed++;
      $display("FAIL threshold_equal: got %0d pulses, first %s expected 1 pulse %s",
               got_q.size(), got_q.size() > 0 ? fmt(got_q[0]) : "none", fmt(exp_r));
    end
  endtask

  task automatic test_back_to_back();
    res_t exp_a;
    res_t exp_b;
    int unsigned e0a;
    int unsigned e0b;
    clear_frame();
    clear_got();
    frame[10] = 32'h4000_0000;
    bus.mag_thresh = 32'd1;
    drive_frame(0, e0a);
    clear_frame();
    frame[255] = 32'h0000_2000;
    frame[256] = 32'h4000_0000;
    drive_frame(0, e0b);
    idle(5);
    exp_a = '{found: 1'b1, bin: 9'd10,  mag: 32'h1000_0000, freq: 17'd937};
    exp_b = '{found: 1'b1, bin: 9'd255, mag: 32'h0400_0000, freq: 17'd23906};
    tests_run++;
    if (got_q.size() !== 2) begin
      tests_failed++;
      $display("FAIL back_to_back_count: got %0d pulses expected 2", got_q.size());
    end
    if (got_q.size() == 2) begin
      tests_run++;
      if (got_cyc_q[1] - got_cyc_q[0] !== 512 || got_cyc_q[1] !== e0b + 2) begin
        tests_failed++;
        $display("FAIL back_to_back_spacing: got cycles %0d,%0d expected %0d,%0d",
                 got_cyc_q[0], got_cyc_q[1], e0a + 2, e0b + 2);
      end
      tests_run++;
      if (got_q[0] !== exp_a) begin
        tests_failed++;
        $display("FAIL back_to_back_first: got %s expected %s", fmt(got_q[0]), fmt(exp_a));
      end
      tests_run++;
      if (got_q[1] !== exp_b) begin
        tests_failed++;
        $display("FAIL back_to_back_second: got %s expected %s", fmt(got_q[1]), fmt(exp_b));
      end
    end
  endtask

  task automatic test_random_gaps();
    res_t ref0;
    res_t exp_r;
    logic [31:0] thr;
    logic [15:0] re;
    logic [15:0] im;
    int unsigned e0;
    for (int r = 0; r < 4; r++) begin
      clear_got();
      for (int i = 0; i < FSZ; i++) begin
        if (r % 2 == 0) begin
          re = 16'($urandom_range(0, 6)) - 16'd3;
          im = 16'($urandom_range(0, 6)) - 16'd3;
          frame[i] = {re, im};
        end else begin
          frame[i] = $urandom;
        end
      end
      ref0 = model_frame(32'd0);
      case (r)
        0:       thr = ref0.mag;
        1:       thr = ref0.mag + 32'd1;
        2:       thr = 32'($urandom_range(0, 20));
        default: thr = $urandom;
      endcase
      exp_r = model_frame(thr);
      bus.mag_thresh = thr;
      drive_frame(0, e0);
      exp_q.push_back(exp_r);
      exp_cyc_q.push_back(e0 + 2);
      idle(3);
      drive_frame(30, e0);
      exp_q.push_back(exp_r);
      exp_cyc_q.push_back(e0 + 2);
      idle(5);
      tests_run++;
      if (got_q.size() !== exp_q.size()) begin
        tests_failed++;
        $display("FAIL random_%0d_count: got %0d pulses expected %0d", r, got_q.size(),
                 exp_q.size());
      end
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
        tests_run++;
        if (got_q[j] !== res_t'(exp_q[j]) || got_cyc_q[j] !== exp_cyc_q[j]) begin
          tests_failed++;
          $display("FAIL random_%0d_run%0d: got %s at cycle %0d expected %s at cycle %0d", r, j,
                   fmt(got_q[j]), got_cyc_q[j], fmt(res_t'(exp_q[j])), exp_cyc_q[j]);
        end
      end
    end
  endtask

  task automatic test_resync();
    res_t exp_r;
    int unsigned e0;
    clear_frame();
    clear_got();
    frame[50] = 32'h7fff_0000;
    bus.mag_thresh = 32'd1;
    for (int i = 0; i < 100; i++) drive_bin(frame[i], i == 0);
    clear_frame();
    frame[30] = 32'h2000_2000;
    drive_frame(0, e0);
    idle(5);
    exp_r = '{found: 1'b1, bin: 9'd30, mag: 32'h0800_0000, freq: 17'd2812};
    tests_run++;
    if (got_q.size() !== 1) begin
      tests_failed++;
      $display("FAIL resync_count: got %0d pulses expected 1", got_q.size());
    end
    if (got_q.size() > 0) begin
      tests_run++;
      if (got_q[0] !== exp_r || got_cyc_q[0] !== e0 + 2) begin
        tests_failed++;
        $display("FAIL resync_result: got %s at cycle %0d expected %s at cycle %0d",
                 fmt(got_q[0]), got_cyc_q[0], fmt(exp_r), e0 + 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    res_t now;
    res_t exp_r;
    int unsigned e0;
    clear_frame();
    clear_got();
    frame[10] = 32'h4000_0000;
    bus.mag_thresh = 32'd1;
    // Reset in the middle of a cycle, mid-frame: outputs clear without waiting for a clock.
    for (int i = 0; i < 200; i++) drive_bin(frame[i], i == 0);
    #2 reset = 1'b1;
    #1;
    now = '{found: bus.peak_found, bin: bus.peak_bin, mag: bus.peak_mag, freq: bus.frequency};
    tests_run++;
    if (now !== res_t'(0) || bus.peak_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async_outputs: got %s valid=%b expected all zero", fmt(now),
               bus.peak_valid);
    end
    bus.bin_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    // The rest of the interrupted frame is not a full frame after reset.
    for (int i = 200; i < FSZ; i++) drive_bin(frame[i], 1'b0);
    idle(5);
    tests_run++;
    if (got_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL reset_partial_frame: got %0d pulses expected 0", got_q.size());
    end
    // Reset after the magnitude stage holds the last bin, before the report edge.
    drive_frame(0, e0);
    bus.bin_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(5);
    tests_run++;
    if (got_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_pipeline: got %0d pulses expected 0", got_q.size());
    end
    clear_frame();
    frame[255] = 32'h0000_2000;
    drive_frame(0, e0);
    idle(5);
    exp_r = '{found: 1'b1, bin: 9'd255, mag: 32'h0400_0000, freq: 17'd23906};
    tests_run++;
    if (got_q.size() !== 1 || got_q[0] !== exp_r || got_cyc_q[0] !== e0 + 2) begin
      tests_failed++;
      $display("FAIL reset_recovery: got %0d pulses, first %s expected 1 pulse %s at cycle %0d",
               got_q.size(), got_q.size() > 0 ? fmt(got_q[0]) : "none", fmt(exp_r), e0 + 2);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset           = 1'b1;
    bus.bin_valid   = 1'b0;
    bus.bin_data    = '0;
    bus.frame_start = 1'b0;
    bus.mag_thresh  = '0;
    #1;
    test_reset();
    test_single_tone();
    test_tie_window();
    test_threshold();
    test_back_to_back();
    test_random_gaps();
    test_resync();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
